long_multiplier_iterative: RTL

Multi-cycle, parametrised long (shift-and-add) integer multiplier for the Integer/Multipliers library. It is the sequential successor of the single combinational product row. It folds the partial-product array over time, accumulating ROWS_PER_CYCLE rows per clock. It supports signed (two's complement) and unsigned operands and uses a valid/ready input handshake. It sits beside the combinational array multipliers for area-constrained datapaths.

---
 rtl/long_multiplier_iterative_if.sv | 40 ++++
 rtl/long_multiplier_iterative.sv | 115 +++++++++++
 2 files changed

// File: rtl/long_multiplier_iterative_if.sv
// Operand/result bundle for the iterative long multiplier.
// Signals:
//   valid_i        - operands and mode valid this cycle (master -> slave)
//   ready_o        - multiplier idle and able to accept (slave -> master)
//   signed_i       - 1: both operands two's complement, 0: both unsigned
//   multiplicand_i - operand A, DATA_WIDTH bits
//   multiplier_i   - operand B, DATA_WIDTH bits
//   product_o      - full 2*DATA_WIDTH product, held until next result
//   valid_o        - one-cycle pulse marking a fresh product_o
interface long_multiplier_iterative_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      valid_i;
    logic                      ready_o;
    logic                      signed_i;
    logic [DATA_WIDTH-1:0]     multiplicand_i;
    logic [DATA_WIDTH-1:0]     multiplier_i;
    logic [2*DATA_WIDTH-1:0]   product_o;
    logic                      valid_o;

    modport master (
        output valid_i,
        output signed_i,
        output multiplicand_i,
        output multiplier_i,
        input  ready_o,
        input  product_o,
        input  valid_o
    );

    modport slave (
        input  valid_i,
        input  signed_i,
        input  multiplicand_i,
        input  multiplier_i,
        output ready_o,
        output product_o,
        output valid_o
    );
endinterface

// File: rtl/long_multiplier_iterative.sv
// Sequential shift-and-add multiplier, ROWS_PER_CYCLE partial rows per clock.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset
//   bus   - slave side of long_multiplier_iterative_if (operands in,
//           ready_o / product_o / valid_o out)
// Signed operands are reduced to magnitudes on accept; the sign is
// reapplied once when the final product is registered.
module long_multiplier_iterative #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROWS_PER_CYCLE = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    long_multiplier_iterative_if.slave    bus
);
    localparam int ITER = DATA_WIDTH / ROWS_PER_CYCLE;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [PW-1:0]         r_acc;
    logic [PW-1:0]         r_mcand;
    logic [DATA_WIDTH-1:0] r_mplr;
    logic                  r_neg;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_product;
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_neg;
    logic [PW-1:0]         w_rows;
    logic [PW-1:0]         w_sum;
    logic                  w_last;

    // Negating the most negative value wraps back onto itself, which read
    // as unsigned is exactly its magnitude.
    assign w_mag_a = (bus.signed_i && bus.multiplicand_i[DATA_WIDTH-1])
                   ? (DATA_WIDTH'(0) - bus.multiplicand_i)
                   : bus.multiplicand_i;
    assign w_mag_b = (bus.signed_i && bus.multiplier_i[DATA_WIDTH-1])
                   ? (DATA_WIDTH'(0) - bus.multiplier_i)
                   : bus.multiplier_i;
    assign w_neg   = bus.signed_i &
                     (bus.multiplicand_i[DATA_WIDTH-1] ^
                      bus.multiplier_i[DATA_WIDTH-1]);

    // r_mcand is already pre-shifted to the weight of r_mplr[0].
    always_comb begin
        w_rows = '0;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            if (r_mplr[j]) begin
                w_rows = w_rows + (r_mcand << j);
            end
        end
    end

    assign w_sum  = r_acc + w_rows;
    assign w_last = (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.valid_i) begin
                        r_mcand <= {{DATA_WIDTH{1'b0}}, w_mag_a};
                        r_mplr  <= w_mag_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc   <= w_sum;
                    r_mcand <= r_mcand << ROWS_PER_CYCLE;
                    r_mplr  <= r_mplr >> ROWS_PER_CYCLE;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= r_neg ? (PW'(0) - w_sum) : w_sum;
                        r_valid   <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = (r_state == S_IDLE);
    assign bus.product_o = r_product;
    assign bus.valid_o   = r_valid;
endmodule
